// File: rtl/flag_bank_if.sv
// Bus bundle between the datapath and the banked condition-flag register.
// master drives the flag-update and read-select controls; slave is the flag bank.
interface flag_bank_if #(
  parameter int NFLAGS = 4,
  parameter int NCTX   = 2,
  parameter int CTXW   = (NCTX > 1) ? $clog2(NCTX) : 1
);

  // Update side
  logic              set_flag;
  logic [CTXW-1:0]   wr_ctx;
  logic [NFLAGS-1:0] wr_mask;
  logic [NFLAGS-1:0] flags_in;
  logic              save;
  logic              restore;

  // Read side
  logic [CTXW-1:0]   rd_ctx;
  logic [3:0]        cond;
  logic [NFLAGS-1:0] flags_out;
  logic              cond_true;
  logic              err;

  modport master (
    output set_flag, wr_ctx, wr_mask, flags_in, save, restore, rd_ctx, cond,
    input  flags_out, cond_true, err
  );

  modport slave (
    input  set_flag, wr_ctx, wr_mask, flags_in, save, restore, rd_ctx, cond,
    output flags_out, cond_true, err
  );

endinterface

// File: rtl/flag_bank.sv
// Banked condition-flag register: NCTX independent live flag sets, each with
// a one-deep save/restore shadow, masked updates from the ALU, an optional
// same-cycle write->read bypass and an ARM B.cond evaluator on the read port.
// Flag bit order is {.., N, Z, C, V} with V at bit 0.
module flag_bank #(
  parameter int NFLAGS = 4,
  parameter int NCTX   = 2,
  parameter int BYPASS = 1,
  parameter int CTXW   = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic       clk,
  input  logic       reset,
  flag_bank_if.slave bus
);

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------

  // Masked merge: new bits where mask is set, old bits elsewhere.
  function automatic logic [NFLAGS-1:0] merge_flags(
    input logic [NFLAGS-1:0] old_val,
    input logic [NFLAGS-1:0] new_val,
    input logic [NFLAGS-1:0] mask
  );
    merge_flags = (new_val & mask) | (old_val & ~mask);
  endfunction

  // ARM condition-code evaluation against {N,Z,C,V}.
  function automatic logic eval_cond(
    input logic [3:0] cc,
    input logic [3:0] nzcv
  );
    logic n, z, c, v, r;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cc)
      4'h0:    r = z;                    // EQ
      4'h1:    r = ~z;                   // NE
      4'h2:    r = c;                    // CS
      4'h3:    r = ~c;                   // CC
      4'h4:    r = n;                    // MI
      4'h5:    r = ~n;                   // PL
      4'h6:    r = v;                    // VS
      4'h7:    r = ~v;                   // VC
      4'h8:    r = c & ~z;               // HI
      4'h9:    r = ~c | z;               // LS
      4'hA:    r = (n == v);             // GE
      4'hB:    r = (n != v);             // LT
      4'hC:    r = ~z & (n == v);        // GT
      4'hD:    r = z | (n != v);         // LE
      default: r = 1'b1;                 // AL / NV
    endcase
    eval_cond = r;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [NFLAGS-1:0] live_r        [NCTX];
  logic [NFLAGS-1:0] shadow_r      [NCTX];
  logic [NCTX-1:0]   shadow_valid_r;
  logic              err_r;

  logic [NFLAGS-1:0] live_nxt_s    [NCTX];
  logic [NFLAGS-1:0] shadow_nxt_s  [NCTX];
  logic [NCTX-1:0]   shadow_valid_nxt_s;
  logic              err_nxt_s;

  logic              any_op_s;
  logic              wr_in_range_s;
  logic              rd_in_range_s;
  logic [NFLAGS-1:0] rd_live_s;
  logic              bypass_hit_s;
  logic [NFLAGS-1:0] flags_out_s;

  assign any_op_s = bus.set_flag | bus.save | bus.restore;

  // Decode whether the write/read context indices name an existing context;
  // with a non-power-of-two NCTX the top encodings are unused.
  always_comb begin
    wr_in_range_s = 1'b0;
    rd_in_range_s = 1'b0;
    rd_live_s     = {NFLAGS{1'b0}};
    for (int c = 0; c < NCTX; c++) begin
      if (bus.wr_ctx == CTXW'(c)) begin
        wr_in_range_s = 1'b1;
      end else begin
        wr_in_range_s = wr_in_range_s;
      end
      if (bus.rd_ctx == CTXW'(c)) begin
        rd_in_range_s = 1'b1;
        rd_live_s     = live_r[c];
      end else begin
        rd_in_range_s = rd_in_range_s;
        rd_live_s     = rd_live_s;
      end
    end
  end

  // Next-state for live flags, shadows and the sticky error. Restore wins
  // over set_flag; save always captures the pre-edge live value, which gives
  // swap semantics when save and restore arrive together.
  always_comb begin
    for (int c = 0; c < NCTX; c++) begin
      live_nxt_s[c]         = live_r[c];
      shadow_nxt_s[c]       = shadow_r[c];
      shadow_valid_nxt_s[c] = shadow_valid_r[c];
    end
    err_nxt_s = err_r;

    if (any_op_s && !wr_in_range_s) begin
      // Nonexistent context: no state change, flag the error.
      err_nxt_s = 1'b1;
    end else begin
      for (int c = 0; c < NCTX; c++) begin
        if (any_op_s && (bus.wr_ctx == CTXW'(c))) begin
          if (bus.save) begin
            shadow_nxt_s[c]       = live_r[c];
            shadow_valid_nxt_s[c] = 1'b1;
          end else begin
            shadow_nxt_s[c]       = shadow_r[c];
          end

          if (bus.restore) begin
            if (shadow_valid_r[c]) begin
              live_nxt_s[c] = shadow_r[c];
              // A simultaneous save refills the shadow, so it stays valid.
              if (!bus.save) begin
                shadow_valid_nxt_s[c] = 1'b0;
              end else begin
                shadow_valid_nxt_s[c] = 1'b1;
              end
            end else begin
              // Restore from an empty shadow: live holds.
              live_nxt_s[c] = live_r[c];
              err_nxt_s     = 1'b1;
            end
          end else if (bus.set_flag) begin
            live_nxt_s[c] = merge_flags(live_r[c], bus.flags_in, bus.wr_mask);
          end else begin
            live_nxt_s[c] = live_r[c];
          end
        end else begin
          live_nxt_s[c] = live_r[c];
        end
      end
    end
  end

  // Flag storage with asynchronous clear of every context, shadow and error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCTX; c++) begin
        live_r[c]   <= {NFLAGS{1'b0}};
        shadow_r[c] <= {NFLAGS{1'b0}};
      end
      shadow_valid_r <= {NCTX{1'b0}};
      err_r          <= 1'b0;
    end else begin
      for (int c = 0; c < NCTX; c++) begin
        live_r[c]   <= live_nxt_s[c];
        shadow_r[c] <= shadow_nxt_s[c];
      end
      shadow_valid_r <= shadow_valid_nxt_s;
      err_r          <= err_nxt_s;
    end
  end

  // Read port: optionally forward a same-cycle set_flag to the read context.
  // Restore is never forwarded; the read is forced to zero while in reset.
  always_comb begin
    bypass_hit_s = (BYPASS != 0) && bus.set_flag && !bus.restore &&
                   wr_in_range_s && rd_in_range_s && (bus.wr_ctx == bus.rd_ctx);
    if (!reset) begin
      flags_out_s = {NFLAGS{1'b0}};
    end else if (bypass_hit_s) begin
      flags_out_s = merge_flags(rd_live_s, bus.flags_in, bus.wr_mask);
    end else begin
      flags_out_s = rd_live_s;
    end
  end

  assign bus.flags_out = flags_out_s;
  assign bus.cond_true = eval_cond(bus.cond, flags_out_s[3:0]);
  assign bus.err       = err_r;

endmodule

// File: tb/tb_flag_bank.sv
// Directed bench for flag_bank: a bypassing and a registered-only instance
// with two contexts, plus a three-context instance for out-of-range indices.
module tb_flag_bank;

  logic clk;
  logic reset;

  // Shared stimulus for the two-context instances
  logic       set_flag;
  logic [0:0] wr_ctx;
  logic [3:0] wr_mask;
  logic [3:0] flags_in;
  logic       save;
  logic       restore;
  logic [0:0] rd_ctx;
  logic [3:0] cond;

  int checks;
  int errors;

  flag_bank_if #(.NFLAGS(4), .NCTX(2)) ifa ();
  flag_bank_if #(.NFLAGS(4), .NCTX(2)) ifb ();
  flag_bank_if #(.NFLAGS(4), .NCTX(3)) ifc ();

  assign ifa.set_flag = set_flag;
  assign ifa.wr_ctx   = wr_ctx;
  assign ifa.wr_mask  = wr_mask;
  assign ifa.flags_in = flags_in;
  assign ifa.save     = save;
  assign ifa.restore  = restore;
  assign ifa.rd_ctx   = rd_ctx;
  assign ifa.cond     = cond;

  assign ifb.set_flag = set_flag;
  assign ifb.wr_ctx   = wr_ctx;
  assign ifb.wr_mask  = wr_mask;
  assign ifb.flags_in = flags_in;
  assign ifb.save     = save;
  assign ifb.restore  = restore;
  assign ifb.rd_ctx   = rd_ctx;
  assign ifb.cond     = cond;

  flag_bank #(.NFLAGS(4), .NCTX(2), .BYPASS(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  flag_bank #(.NFLAGS(4), .NCTX(2), .BYPASS(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  flag_bank #(.NFLAGS(4), .NCTX(3), .BYPASS(1)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ab();
    set_flag = 1'b0;
    save     = 1'b0;
    restore  = 1'b0;
  endtask

  task automatic write_ab(input logic [0:0] ctx, input logic [3:0] mask, input logic [3:0] val);
    set_flag = 1'b1;
    wr_ctx   = ctx;
    wr_mask  = mask;
    flags_in = val;
    step();
    idle_ab();
  endtask

  task automatic write_c(input logic [1:0] ctx, input logic [3:0] val);
    ifc.set_flag = 1'b1;
    ifc.wr_ctx   = ctx;
    ifc.wr_mask  = 4'hF;
    ifc.flags_in = val;
    step();
    ifc.set_flag = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset    = 1'b0;
    set_flag = 1'b0;
    wr_ctx   = 1'b0;
    wr_mask  = 4'h0;
    flags_in = 4'h0;
    save     = 1'b0;
    restore  = 1'b0;
    rd_ctx   = 1'b0;
    cond     = 4'h0;
    ifc.set_flag = 1'b0;
    ifc.wr_ctx   = 2'd0;
    ifc.wr_mask  = 4'h0;
    ifc.flags_in = 4'h0;
    ifc.save     = 1'b0;
    ifc.restore  = 1'b0;
    ifc.rd_ctx   = 2'd0;
    ifc.cond     = 4'h0;

    // Reset state
    #1;
    chk("rst_flags_a", 32'(ifa.flags_out), 32'h0);
    chk("rst_err_a",   32'(ifa.err),       32'h0);
    chk("rst_eq_a",    32'(ifa.cond_true), 32'h0);
    step();
    reset = 1'b1;
    step();

    // Full-mask write on ctx0: bypass shows it now, registered copy after edge
    set_flag = 1'b1; wr_ctx = 1'b0; rd_ctx = 1'b0; wr_mask = 4'hF; flags_in = 4'b0100;
    #1;
    chk("byp_wr_a", 32'(ifa.flags_out), 32'h4);
    chk("reg_wr_b", 32'(ifb.flags_out), 32'h0);
    step();
    idle_ab();
    #1;
    chk("wr_a", 32'(ifa.flags_out), 32'h4);
    chk("wr_b", 32'(ifb.flags_out), 32'h4);
    chk("eq_a", 32'(ifa.cond_true), 32'h1);

    // Partial mask sets only C
    write_ab(1'b0, 4'b0010, 4'hF);
    chk("mask_a", 32'(ifa.flags_out), 32'h6);
    chk("mask_b", 32'(ifb.flags_out), 32'h6);
    flags_in = 4'hF; wr_mask = 4'hF;          // ignored without set_flag
    rd_ctx = 1'b1;
    #1;
    chk("ctx1_zero_a", 32'(ifa.flags_out), 32'h0);
    step();
    rd_ctx = 1'b0;
    #1;
    chk("hold_a", 32'(ifa.flags_out), 32'h6);

    // Bypass of N on ctx1; LT follows N != V
    rd_ctx = 1'b1; cond = 4'hB;
    set_flag = 1'b1; wr_ctx = 1'b1; wr_mask = 4'b1000; flags_in = 4'b1000;
    #1;
    chk("byp_n_a",  32'(ifa.flags_out), 32'h8);
    chk("byp_lt_a", 32'(ifa.cond_true), 32'h1);
    chk("nobyp_b",  32'(ifb.flags_out), 32'h0);
    chk("nolt_b",   32'(ifb.cond_true), 32'h0);
    step();
    idle_ab();
    #1;
    chk("post_n_b",  32'(ifb.flags_out), 32'h8);
    chk("post_lt_b", 32'(ifb.cond_true), 32'h1);
    rd_ctx = 1'b0;
    #1;
    chk("ctx0_kept_a", 32'(ifa.flags_out), 32'h6);

    // Save / write / restore / restore-from-empty on ctx0
    write_ab(1'b0, 4'hF, 4'h9);
    save = 1'b1; wr_ctx = 1'b0;
    step();
    idle_ab();
    write_ab(1'b0, 4'hF, 4'h2);
    chk("after_save_wr", 32'(ifa.flags_out), 32'h2);
    restore = 1'b1;
    #1;
    chk("restore_nobyp", 32'(ifa.flags_out), 32'h2);
    step();
    idle_ab();
    #1;
    chk("restored",  32'(ifa.flags_out), 32'h9);
    chk("err_clean", 32'(ifa.err),       32'h0);
    restore = 1'b1;
    step();
    idle_ab();
    #1;
    chk("empty_rst_live", 32'(ifa.flags_out), 32'h9);
    chk("empty_rst_err",  32'(ifa.err),       32'h1);
    chk("empty_rst_err_b", 32'(ifb.err),      32'h1);

    // Asynchronous reset mid-stream with flags all set
    write_ab(1'b0, 4'hF, 4'hF);
    chk("pre_rst_flags", 32'(ifa.flags_out), 32'hF);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_flags", 32'(ifa.flags_out), 32'h0);
    chk("async_rst_err",   32'(ifa.err),       32'h0);
    chk("async_rst_eq",    32'(ifa.cond_true), 32'h0);
    step();
    reset = 1'b1;
    step();

    // Save + restore + set_flag in one cycle: swap, set_flag loses
    write_ab(1'b0, 4'hF, 4'h6);
    save = 1'b1; wr_ctx = 1'b0;
    step();
    idle_ab();
    write_ab(1'b0, 4'hF, 4'h1);
    save = 1'b1; restore = 1'b1; set_flag = 1'b1; wr_mask = 4'hF; flags_in = 4'hF;
    #1;
    chk("swap_nobyp", 32'(ifa.flags_out), 32'h1);
    step();
    idle_ab();
    #1;
    chk("swap_live", 32'(ifa.flags_out), 32'h6);
    restore = 1'b1;
    step();
    idle_ab();
    #1;
    chk("swap_shadow", 32'(ifa.flags_out), 32'h1);
    chk("swap_valid",  32'(ifa.err),       32'h0);

    // Three contexts: index 3 does not exist
    write_c(2'd2, 4'h5);
    write_c(2'd0, 4'hA);
    ifc.rd_ctx = 2'd2;
    #1;
    chk("c_ctx2", 32'(ifc.flags_out), 32'h5);
    chk("c_err0", 32'(ifc.err),       32'h0);
    write_c(2'd3, 4'hF);
    chk("c_oor_err", 32'(ifc.err),       32'h1);
    chk("c_ctx2_kept", 32'(ifc.flags_out), 32'h5);
    ifc.rd_ctx = 2'd1;
    #1;
    chk("c_ctx1_kept", 32'(ifc.flags_out), 32'h0);
    ifc.rd_ctx = 2'd3;
    #1;
    chk("c_rd_oor", 32'(ifc.flags_out), 32'h0);

    // Condition codes: ctx2 = 0101 (Z,V), ctx0 = 1010 (N,C)
    ifc.rd_ctx = 2'd2;
    ifc.cond = 4'h8; #1; chk("c2_hi", 32'(ifc.cond_true), 32'h0);
    ifc.cond = 4'h9; #1; chk("c2_ls", 32'(ifc.cond_true), 32'h1);
    ifc.cond = 4'hA; #1; chk("c2_ge", 32'(ifc.cond_true), 32'h0);
    ifc.cond = 4'hD; #1; chk("c2_le", 32'(ifc.cond_true), 32'h1);
    ifc.cond = 4'h6; #1; chk("c2_vs", 32'(ifc.cond_true), 32'h1);
    ifc.rd_ctx = 2'd0;
    ifc.cond = 4'h8; #1; chk("c0_hi", 32'(ifc.cond_true), 32'h1);
    ifc.cond = 4'hC; #1; chk("c0_gt", 32'(ifc.cond_true), 32'h0);
    ifc.cond = 4'h4; #1; chk("c0_mi", 32'(ifc.cond_true), 32'h1);
    ifc.cond = 4'h1; #1; chk("c0_ne", 32'(ifc.cond_true), 32'h1);
    ifc.cond = 4'h3; #1; chk("c0_cc", 32'(ifc.cond_true), 32'h0);
    ifc.cond = 4'hF; #1; chk("c0_al", 32'(ifc.cond_true), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
